// File: rtl/lock_key_pkg.sv
// Shared types and constants for the serial key loader that unlocks a MUX key-gated netlist.
// The checksum fold is defined here so that the loader and anything else needing it agree.
package lock_key_pkg;

  localparam int KEY_W    = 6;
  localparam int CHK_W    = 4;
  localparam int MAX_FAIL = 3;
  localparam int FRAME_W  = KEY_W + CHK_W;
  localparam int CNT_W    = $clog2(FRAME_W + 1);
  localparam int FAIL_W   = $clog2(MAX_FAIL + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CHECK   = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  // XOR of CHK_W-bit key chunks, LSB chunk first; a short top chunk is implicitly zero-padded.
  function automatic logic [CHK_W-1:0] chk_fold(input logic [KEY_W-1:0] key);
    logic [CHK_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < KEY_W; i++) begin
      acc[i % CHK_W] = acc[i % CHK_W] ^ key[i];
    end
    return acc;
  endfunction

endpackage

// File: rtl/lock_key_shreg.sv
// Bit counter and LSB-first shift register for one key frame (key bits, then check bits).
// last_bit flags the cycle in which the final bit of the frame is being accepted.
module lock_key_shreg
  import lock_key_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [KEY_W-1:0] key,
  output logic [CHK_W-1:0] chk,
  output logic             full,
  output logic             last_bit
);

  logic [FRAME_W-1:0] sr;
  logic [CNT_W-1:0]   cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sr  <= '0;
      cnt <= '0;
    end else if (shift_en && !full) begin
      // New bits enter at the top so the first bit received ends up in bit 0.
      sr  <= {bit_in, sr[FRAME_W-1:1]};
      cnt <= cnt + 1'b1;
    end
  end

  assign full     = (cnt == CNT_W'(FRAME_W));
  assign last_bit = shift_en && (cnt == CNT_W'(FRAME_W - 1));
  assign key      = sr[KEY_W-1:0];
  assign chk      = sr[FRAME_W-1:KEY_W];

endmodule

// File: rtl/lock_key_loader.sv
// Receives the serial key frame, checks it and drives the key bus of the locked core.
// The key stays all-zero until a checksum-valid frame commits; repeated failures lock the loader out.
module lock_key_loader
  import lock_key_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             kin_start,
  input  logic             kin_valid,
  input  logic             kin_data,
  output logic             kin_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             done,
  output logic             err,
  output logic             lockout
);

  state_t              state, state_nxt;
  logic [FAIL_W-1:0]   fail_cnt, fail_nxt;
  logic [KEY_W-1:0]    rx_key;
  logic [CHK_W-1:0]    rx_chk;
  logic                rx_full, last_bit;
  logic                restart, accept, pass;

  assign kin_ready = (state == SHIFT);
  assign restart   = kin_start && ((state == IDLE) || (state == SHIFT));
  // A start in the same cycle as a valid bit wins; that bit is dropped.
  assign accept    = kin_valid && kin_ready && !kin_start;

  lock_key_shreg u_shreg (
    .clk      (clk),
    .rst      (rst),
    .clr      (restart),
    .shift_en (accept),
    .bit_in   (kin_data),
    .key      (rx_key),
    .chk      (rx_chk),
    .full     (rx_full),
    .last_bit (last_bit)
  );

  always_comb begin
    state_nxt = state;
    pass      = rx_full && (rx_chk == chk_fold(rx_key));
    fail_nxt  = (fail_cnt == FAIL_W'(MAX_FAIL)) ? fail_cnt : fail_cnt + 1'b1;
    case (state)
      IDLE:    if (restart) state_nxt = SHIFT;
      SHIFT:   if (restart) state_nxt = SHIFT;
               else if (last_bit) state_nxt = CHECK;
      CHECK:   if (pass) state_nxt = IDLE;
               else if (fail_nxt == FAIL_W'(MAX_FAIL)) state_nxt = LOCKOUT;
               else state_nxt = IDLE;
      LOCKOUT: state_nxt = LOCKOUT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      fail_cnt  <= '0;
      key_out   <= '0;
      key_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      lockout   <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == CHECK);
      if (restart) err <= 1'b0;
      if (state == CHECK) begin
        if (pass) begin
          key_out   <= rx_key;
          key_valid <= 1'b1;
          err       <= 1'b0;
        end else begin
          err      <= 1'b1;
          fail_cnt <= fail_nxt;
        end
      end
      // Entering lockout re-locks the core regardless of any earlier commit.
      if (state_nxt == LOCKOUT) begin
        key_out   <= '0;
        key_valid <= 1'b0;
        lockout   <= 1'b1;
      end
    end
  end

endmodule
